// File: rtl/io_regfile_pkg.sv
// io_regfile_pkg
// Shared definitions for the memory-mapped game I/O register file:
//   - default data width and default register-window indices
//   - reserved register indices
//   - register classification used by the read/write decoders
//   - channel slice offset helper and a layout legality check
package io_regfile_pkg;

  localparam int DATA_W_DEF    = 32;
  localparam int IN_BASE_DEF   = 16;
  localparam int OUT_BASE_DEF  = 20;
  localparam int FRAME_REG_DEF = 26;
  localparam int FLAG_REG_DEF  = 27;

  localparam int NUM_REGS = 32;
  localparam int REG_AW   = 5;

  // 0 is hardwired zero; 30/31 are kept out of the I/O window (link/stack use)
  localparam logic [REG_AW-1:0] REG_ZERO   = 5'd0;
  localparam logic [REG_AW-1:0] REG_RSVD30 = 5'd30;
  localparam logic [REG_AW-1:0] REG_RSVD31 = 5'd31;

  typedef enum logic [2:0] {
    RK_ZERO,
    RK_INPUT,
    RK_OUTPUT,
    RK_FRAME,
    RK_FLAG,
    RK_PLAIN
  } reg_kind_e;

  // Low bit of channel k inside a flattened channel bus.
  function automatic int chan_lo(input int k, input int w);
    return k * w;
  endfunction

  function automatic reg_kind_e reg_kind(input logic [REG_AW-1:0] idx,
                                         input int in_base, input int num_in,
                                         input int out_base, input int num_out,
                                         input int frame_reg, input int flag_reg);
    int i;
    i = int'(idx);
    if (i == 0)                                   return RK_ZERO;
    if (i >= in_base && i < in_base + num_in)     return RK_INPUT;
    if (i >= out_base && i < out_base + num_out)  return RK_OUTPUT;
    if (i == frame_reg)                           return RK_FRAME;
    if (i == flag_reg)                            return RK_FLAG;
    return RK_PLAIN;
  endfunction

  // Every special index must sit in 1..29 and be claimed at most once.
  function automatic bit layout_ok(input int num_in, input int in_base,
                                   input int num_out, input int out_base,
                                   input int frame_reg, input int flag_reg);
    bit [NUM_REGS-1:0] used;
    bit ok;
    int idx;
    used = '0;
    ok   = 1'b1;
    if (num_in < 1 || num_in > 4 || num_out < 1 || num_out > 4) ok = 1'b0;
    for (int k = 0; k < num_in + num_out + 2; k++) begin
      if (k < num_in)                idx = in_base + k;
      else if (k < num_in + num_out) idx = out_base + (k - num_in);
      else if (k == num_in + num_out) idx = frame_reg;
      else                           idx = flag_reg;
      if (idx < 1 || idx > 29) ok = 1'b0;
      else begin
        if (used[idx]) ok = 1'b0;
        used[idx] = 1'b1;
      end
    end
    return ok;
  endfunction

endpackage

// File: rtl/io_regfile_frame_tick_gen.sv
// frame_tick_gen
// Rising-edge detector on the VGA end-of-frame level plus a wrapping frame
// counter. A level held high for many cycles yields a single tick.
// Ports:
//   clock, reset   - system clock, synchronous active-high reset
//   screen_end     - end-of-frame level
//   frame_tick     - one-cycle pulse on the rising edge of screen_end
//   count          - number of ticks seen since reset (wraps)
module frame_tick_gen #(
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              screen_end,
  output logic              frame_tick,
  output logic [DATA_W-1:0] count
);

  logic se_q;

  assign frame_tick = screen_end & ~se_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      se_q  <= 1'b0;
      count <= '0;
    end else begin
      se_q <= screen_end;
      if (frame_tick) count <= count + DATA_W'(1);
    end
  end

endmodule

// File: rtl/io_regfile.sv
// io_regfile
// 32-entry processor register file with a window of memory-mapped game I/O:
//   - NUM_IN read-only input channels, snapshotted on each frame tick
//   - NUM_OUT read/write output shadows, published to io_out on each tick
//   - FRAME_REG: read-only frame counter, FLAG_REG: frame-sync flag (bit 0)
// Reads are combinational with write-through bypass for ordinary registers.
// Ports:
//   clock, reset                 - system clock, synchronous active-high reset
//   ctrl_writeEnable/WriteReg    - processor write strobe and index
//   ctrl_readRegA/B              - read port indices
//   data_writeReg                - write data
//   data_readRegA/B              - read port data
//   screenEnd                    - end-of-frame level from the VGA controller
//   io_in                        - flattened input channels
//   io_out                       - flattened published output channels
//   frame_count                  - mirror of the frame counter
// Build option: define IO_OUT_DIRECT_EN to drive io_out straight from the
// output shadows (no frame latching).
module io_regfile
  import io_regfile_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int NUM_IN    = 2,
  parameter int NUM_OUT   = 2,
  parameter int IN_BASE   = IN_BASE_DEF,
  parameter int OUT_BASE  = OUT_BASE_DEF,
  parameter int FRAME_REG = FRAME_REG_DEF,
  parameter int FLAG_REG  = FLAG_REG_DEF
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      ctrl_writeEnable,
  input  logic [4:0]                ctrl_writeReg,
  input  logic [4:0]                ctrl_readRegA,
  input  logic [4:0]                ctrl_readRegB,
  input  logic [DATA_W-1:0]         data_writeReg,
  output logic [DATA_W-1:0]         data_readRegA,
  output logic [DATA_W-1:0]         data_readRegB,
  input  logic                      screenEnd,
  input  logic [NUM_IN*DATA_W-1:0]  io_in,
  output logic [NUM_OUT*DATA_W-1:0] io_out,
  output logic [DATA_W-1:0]         frame_count
);

  if (!layout_ok(NUM_IN, IN_BASE, NUM_OUT, OUT_BASE, FRAME_REG, FLAG_REG)) begin : g_bad_layout
    $error("io_regfile: I/O register window overlaps or uses a reserved index");
  end

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              flag;
  logic              frame_tick;
  logic [DATA_W-1:0] count;
  reg_kind_e         wr_kind;
  logic [NUM_IN-1:0][DATA_W-1:0] in_ch;

  frame_tick_gen #(.DATA_W(DATA_W)) u_tick (
    .clock      (clock),
    .reset      (reset),
    .screen_end (screenEnd),
    .frame_tick (frame_tick),
    .count      (count)
  );

  assign frame_count = count;
  assign wr_kind = reg_kind(ctrl_writeReg, IN_BASE, NUM_IN, OUT_BASE, NUM_OUT,
                            FRAME_REG, FLAG_REG);

  for (genvar k = 0; k < NUM_IN; k++) begin : g_in
    assign in_ch[k] = io_in[chan_lo(k, DATA_W) +: DATA_W];
  end

  // Register storage. Input slots are only ever loaded by the tick, so the
  // processor-write and snapshot paths never target the same entry.
  always_ff @(posedge clock) begin
    if (reset) begin
      regs <= '{default: '0};
      flag <= 1'b0;
    end else begin
      if (ctrl_writeEnable && (wr_kind == RK_OUTPUT || wr_kind == RK_PLAIN))
        regs[ctrl_writeReg] <= data_writeReg;
      if (frame_tick)
        for (int k = 0; k < NUM_IN; k++) regs[5'(IN_BASE + k)] <= in_ch[k];
      // tick beats a same-cycle clearing write
      if (frame_tick)
        flag <= 1'b1;
      else if (ctrl_writeEnable && wr_kind == RK_FLAG)
        flag <= 1'b0;
    end
  end

`ifdef IO_OUT_DIRECT_EN
  for (genvar k = 0; k < NUM_OUT; k++) begin : g_out
    assign io_out[chan_lo(k, DATA_W) +: DATA_W] = regs[5'(OUT_BASE + k)];
  end
`else
  logic [NUM_OUT-1:0][DATA_W-1:0] pub;

  // Publish shadows on the tick; a write landing in the tick cycle is
  // forwarded so the frame shows the newest value.
  always_ff @(posedge clock) begin
    if (reset) begin
      pub <= '0;
    end else if (frame_tick) begin
      for (int k = 0; k < NUM_OUT; k++) begin
        if (ctrl_writeEnable && ctrl_writeReg == 5'(OUT_BASE + k))
          pub[k] <= data_writeReg;
        else
          pub[k] <= regs[5'(OUT_BASE + k)];
      end
    end
  end

  assign io_out = pub;
`endif

  // Two identical read ports
  logic [1:0][4:0]        rd_idx;
  logic [1:0][DATA_W-1:0] rd_data;

  assign rd_idx[0]     = ctrl_readRegA;
  assign rd_idx[1]     = ctrl_readRegB;
  assign data_readRegA = rd_data[0];
  assign data_readRegB = rd_data[1];

  for (genvar p = 0; p < 2; p++) begin : g_rd
    reg_kind_e rd_kind;
    assign rd_kind = reg_kind(rd_idx[p], IN_BASE, NUM_IN, OUT_BASE, NUM_OUT,
                              FRAME_REG, FLAG_REG);
    always_comb begin
      rd_data[p] = regs[rd_idx[p]];
      case (rd_kind)
        RK_ZERO:  rd_data[p] = '0;
        RK_INPUT: rd_data[p] = regs[rd_idx[p]];
        RK_FRAME: rd_data[p] = count;
        RK_FLAG:  rd_data[p] = {{(DATA_W-1){1'b0}}, flag};
        default: begin
          if (ctrl_writeEnable && ctrl_writeReg == rd_idx[p])
            rd_data[p] = data_writeReg;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_io_regfile.sv
module tb_io_regfile;

`ifdef IO_OUT_DIRECT_EN
  localparam bit DIRECT = 1'b1;
`else
  localparam bit DIRECT = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        we;
  logic [4:0]  wa, ra, rb;
  logic [31:0] wd;
  logic [31:0] rda, rdb;
  logic        se;
  logic [63:0] io_in;
  logic [63:0] io_out;
  logic [31:0] fc;

  logic        se8;
  logic [7:0]  ra8, rb8, fc8;
  logic [15:0] out8;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  io_regfile dut (
    .clock(clock), .reset(reset),
    .ctrl_writeEnable(we), .ctrl_writeReg(wa),
    .ctrl_readRegA(ra), .ctrl_readRegB(rb),
    .data_writeReg(wd), .data_readRegA(rda), .data_readRegB(rdb),
    .screenEnd(se), .io_in(io_in), .io_out(io_out), .frame_count(fc)
  );

  // narrow instance so counter wrap is reachable in a few hundred cycles
  io_regfile #(.DATA_W(8)) dut8 (
    .clock(clock), .reset(reset),
    .ctrl_writeEnable(1'b0), .ctrl_writeReg(5'd0),
    .ctrl_readRegA(5'd0), .ctrl_readRegB(5'd0),
    .data_writeReg(8'd0), .data_readRegA(ra8), .data_readRegB(rb8),
    .screenEnd(se8), .io_in(16'd0), .io_out(out8), .frame_count(fc8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [4:0] idx, input logic [31:0] d);
    we = 1'b1; wa = idx; wd = d;
    cyc();
    we = 1'b0;
  endtask

  task automatic chk_reg(input string tag, input logic [4:0] idx, input logic [31:0] exp);
    ra = idx;
    #1;
    chk(tag, rda, exp);
  endtask

  task automatic pulse(input int n);
    se = 1'b1;
    repeat (n) cyc();
    se = 1'b0;
    cyc();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; we = 1'b0; wa = '0; ra = '0; rb = '0; wd = '0;
    se = 1'b0; se8 = 1'b0; io_in = '0;
    repeat (2) cyc();
    reset = 1'b0;
    cyc();
    chk_reg("init_r5", 5'd5, 32'h0);
    chk("init_io_out", io_out[31:0], 32'h0);
    chk("init_frame_count", fc, 32'h0);
    chk_reg("init_flag", 5'd27, 32'h0);

    // reset clears storage, published outputs, counter and flag
    wr(5'd5, 32'h55);
    wr(5'd20, 32'h7);
    pulse(1);
    chk_reg("pre_rst_r5", 5'd5, 32'h55);
    chk("pre_rst_io_out", io_out[31:0], 32'h7);
    chk("pre_rst_fc", fc, 32'h1);
    chk_reg("pre_rst_flag", 5'd27, 32'h1);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk_reg("rst_r5", 5'd5, 32'h0);
    chk_reg("rst_r20", 5'd20, 32'h0);
    chk("rst_io_out", io_out[31:0], 32'h0);
    chk("rst_fc", fc, 32'h0);
    chk_reg("rst_flag", 5'd27, 32'h0);

    // input snapshot: 3-cycle screenEnd gives one tick
    io_in = {32'h000000F0, 32'h00000120};
    pulse(3);
    chk("snap_fc", fc, 32'h1);
    chk_reg("snap_r16", 5'd16, 32'h120);
    rb = 5'd17;
    #1;
    chk("snap_r17_b", rdb, 32'hF0);
    io_in = {32'h2, 32'h1};
    repeat (3) cyc();
    chk_reg("snap_hold_r16", 5'd16, 32'h120);
    we = 1'b1; wa = 5'd16; wd = 32'h99; ra = 5'd16;
    #1;
    chk("in_no_bypass", rda, 32'h120);
    cyc();
    we = 1'b0;
    chk_reg("in_write_ignored", 5'd16, 32'h120);

    // double buffering of output shadows
    wr(5'd20, 32'h7);
    chk_reg("shadow_r20", 5'd20, 32'h7);
    chk("dbuf_before_tick", io_out[31:0], DIRECT ? 32'h7 : 32'h0);
    pulse(1);
    chk("dbuf_after_tick", io_out[31:0], 32'h7);
    chk("dbuf_fc", fc, 32'h2);
    se = 1'b1; we = 1'b1; wa = 5'd20; wd = 32'h9;
    cyc();
    we = 1'b0; se = 1'b0;
    cyc();
    chk("dbuf_tick_write", io_out[31:0], 32'h9);
    chk("dbuf_fc3", fc, 32'h3);
    wr(5'd21, 32'h44);
    chk("ch1_after_write", io_out[63:32], DIRECT ? 32'h44 : 32'h0);
    repeat (2) cyc();
    chk("ch1_stable", io_out[63:32], DIRECT ? 32'h44 : 32'h0);
    pulse(1);
    chk("ch1_after_tick", io_out[63:32], 32'h44);
    chk("ch0_kept", io_out[31:0], 32'h9);

    // frame-sync flag
    chk_reg("flag_set", 5'd27, 32'h1);
    wr(5'd27, 32'hFFFF);
    chk_reg("flag_cleared", 5'd27, 32'h0);
    se = 1'b1; we = 1'b1; wa = 5'd27; wd = 32'h0;
    cyc();
    we = 1'b0; se = 1'b0;
    cyc();
    chk_reg("flag_tick_wins", 5'd27, 32'h1);
    chk("flag_fc5", fc, 32'h5);

    // bypass, r0, frame register write
    we = 1'b1; wa = 5'd3; wd = 32'hABCD; ra = 5'd3; rb = 5'd3;
    #1;
    chk("bypass_a", rda, 32'hABCD);
    chk("bypass_b", rdb, 32'hABCD);
    cyc();
    we = 1'b0;
    chk_reg("r3_stored", 5'd3, 32'hABCD);
    we = 1'b1; wa = 5'd0; wd = 32'h5; ra = 5'd0;
    #1;
    chk("r0_no_bypass", rda, 32'h0);
    cyc();
    we = 1'b0;
    chk_reg("r0_zero", 5'd0, 32'h0);
    wr(5'd26, 32'h1234);
    chk_reg("frame_reg_ro", 5'd26, 32'h5);
    chk("frame_count_ro", fc, 32'h5);

    // counter wrap on the 8-bit instance
    repeat (255) begin
      se8 = 1'b1; cyc();
      se8 = 1'b0; cyc();
    end
    chk("wrap_max", {24'h0, fc8}, 32'hFF);
    se8 = 1'b1; cyc();
    se8 = 1'b0; cyc();
    chk("wrap_zero", {24'h0, fc8}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
